center_buf_rd_arb: RTL and testbench
====================================

Name: center_buf_rd_arb

Overview:
- Shares the single read port of the centre buffer between NUM_REQ output-side requesters using round-robin arbitration.
- Owns the buffer write port. Writes are registered and forwarded one cycle later.
- Guarantees read-after-write ordering on same-address collisions.
- Returns read data tagged to the granted requester.
- Sits between the centre buffer and the output channel readers.

Parameters:
- DATA_WIDTH, 256, buffer word width
- DEPTH, 32, buffer entries
- log2_DEPTH, 5, address width
- NUM_REQ, 4, number of read requesters
- log2_NUM_REQ, 2, requester index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_vld  in  1  write request; always accepted
- wr_addr  in  log2_DEPTH  write address
- wr_dat  in  DATA_WIDTH  write data
- req_vld  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*log2_DEPTH  per-requester read address; requester i uses slice [i*log2_DEPTH +: log2_DEPTH]
- req_rdy  out  NUM_REQ  one-hot grant, combinational; handshake is req_vld[i] & req_rdy[i]
- buf_wr_en  out  1  to buffer wr_en
- buf_wr_addr  out  log2_DEPTH  to buffer wr_addr
- buf_wr_dat  out  DATA_WIDTH  to buffer wr_dat
- buf_rd_en  out  1  to buffer rd_en
- buf_rd_addr  out  log2_DEPTH  to buffer rd_addr
- buf_rd_dat_vld  in  1  from buffer
- buf_rd_dat  in  DATA_WIDTH  from buffer
- rsp_vld  out  NUM_REQ  one-hot response valid
- rsp_dat  out  DATA_WIDTH  response data, shared by all requesters

Behaviour:
- Reset (rst=1, async): buf_wr_en=0, buf_rd_en=0, buf_wr_addr=0, buf_rd_addr=0, buf_wr_dat=0, rr_ptr=NUM_REQ-1, pend_tag=0, pend_vld=0.
  - req_rdy=0 while rst is high.
  - rsp_vld=0 while rst is high.
- Write path: at each clk edge, buf_wr_en<=wr_vld, buf_wr_addr<=wr_addr, buf_wr_dat<=wr_dat. Write latency is 1 cycle.
- Eligibility in cycle N: requester i is eligible when req_vld[i]=1 and NOT (wr_vld=1 and wr_addr==req_addr[i]).
  - A colliding read is therefore deferred at least one cycle.
  - Once the write reaches the buffer, the deferred read returns the new data.
- Arbitration: choose the first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_rdy is one-hot on the winner, or all zero if none is eligible.
  - At most one grant per cycle.
- On a grant to index g in cycle N:
  - rr_ptr<=g.
  - Cycle N+1: buf_rd_en=1, buf_rd_addr=req_addr[g] as sampled in N.
  - pend_tag<=g, pend_vld<=1.
  - With no grant: buf_rd_en<=0, pend_vld<=0, rr_ptr holds.
- Response:
  - rsp_vld[i] = buf_rd_dat_vld & pend_vld_d & (pend_tag_d==i), where pend_vld_d and pend_tag_d are pend_vld and pend_tag delayed one cycle to align with buffer read latency.
  - rsp_dat = buf_rd_dat.
  - Total latency from grant cycle N to rsp_vld is 2 cycles (cycle N+2).
- Throughput: one read grant per cycle sustained. Back-to-back grants to the same requester are allowed only if it is the sole eligible requester.
- Fairness: a continuously requesting, non-colliding requester is granted within NUM_REQ cycles.
- Simultaneous events:
  - A read and a write to different addresses in the same cycle proceed together.
  - A write every cycle to the same address as a pending read starves that read. This is permitted; the writer is responsible for avoiding it.
- Reset mid-operation:
  - In-flight tags are dropped.
  - rsp_vld stays 0 even if the buffer (separate reset domain, active-low) still presents buf_rd_dat_vld.
  - After rst deasserts, arbitration restarts from index 0.
- req_addr changing while req_vld=1 without a grant is legal; the value sampled in the grant cycle is used.

Test Plan:
- Write addr 5 = 0xA5 at cycle 0; requester 2 reads addr 5 at cycle 2 -> req_rdy=4'b0100 in cycle 2; buf_rd_en at cycle 3; rsp_vld=4'b0100 and rsp_dat=0xA5 at cycle 4.
- All 4 requesters hold req_vld from reset release, with distinct addresses 0..3 preloaded to 0x10..0x13 -> grants in order 0,1,2,3,0,...; rsp_dat sequence 0x10,0x11,0x12,0x13 on consecutive cycles; each rsp_vld bit matches its tag.
- Collision: cycle N wr_vld=1, addr 7, data 0x77 (old value 0x11) while requester 1 alone requests addr 7 -> req_rdy=0 in N, grant in N+1, rsp_dat=0x77 in N+3; 0x11 is never returned.
- Collision masking: requester 0 collides and requester 3 does not, with rr_ptr=3 -> requester 3 is granted despite lower round-robin priority; requester 0 is granted the next cycle.
- Fairness: requesters 0 and 1 held continuously for 100 cycles -> alternating grants; grant count is 50 each, ±1.
- Reset mid-flight: grant in cycle N, rst pulsed in N+1 -> rsp_vld=0 in N+2; after release the first grant with all requesting goes to requester 0.

Source files
------------

// File: rtl/center_buf_rd_arb.sv
// center_buf_rd_arb: round-robin share of the centre buffer read port with registered write forwarding
module center_buf_rd_arb #(
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 32,
    parameter int log2_DEPTH   = 5,
    parameter int NUM_REQ      = 4,
    parameter int log2_NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_vld,
    input  logic [log2_DEPTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_dat,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ*log2_DEPTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]              req_rdy,
    output logic                            buf_wr_en,
    output logic [log2_DEPTH-1:0]           buf_wr_addr,
    output logic [DATA_WIDTH-1:0]           buf_wr_dat,
    output logic                            buf_rd_en,
    output logic [log2_DEPTH-1:0]           buf_rd_addr,
    input  logic                            buf_rd_dat_vld,
    input  logic [DATA_WIDTH-1:0]           buf_rd_dat,
    output logic [NUM_REQ-1:0]              rsp_vld,
    output logic [DATA_WIDTH-1:0]           rsp_dat
);
    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic                    gnt_any;
    logic [log2_NUM_REQ-1:0] gnt_idx;
    logic [log2_NUM_REQ-1:0] cand;
    logic [log2_NUM_REQ-1:0] rr_ptr;
    logic [log2_NUM_REQ-1:0] pend_tag;
    logic [log2_NUM_REQ-1:0] pend_tag_d;
    logic                    pend_vld;
    logic                    pend_vld_d;

    // a read colliding with this cycle's write waits until the write has reached the buffer
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_vld[i] & ~(wr_vld & (wr_addr == req_addr[i*log2_DEPTH +: log2_DEPTH]));
    end

    // first eligible requester after the last winner wins
    always_comb begin
        gnt_oh  = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = log2_NUM_REQ'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && elig[cand]) begin
                gnt_any      = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

    assign req_rdy = rst ? '0 : gnt_oh;

    // write forwarding, read issue and tag pipeline aligned to the buffer read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_dat  <= '0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            rr_ptr      <= log2_NUM_REQ'(NUM_REQ - 1);
            pend_tag    <= '0;
            pend_vld    <= 1'b0;
            pend_tag_d  <= '0;
            pend_vld_d  <= 1'b0;
        end else begin
            buf_wr_en   <= wr_vld;
            buf_wr_addr <= wr_addr;
            buf_wr_dat  <= wr_dat;
            buf_rd_en   <= gnt_any;
            pend_vld    <= gnt_any;
            pend_tag_d  <= pend_tag;
            pend_vld_d  <= pend_vld;
            if (gnt_any) begin
                buf_rd_addr <= req_addr[gnt_idx*log2_DEPTH +: log2_DEPTH];
                rr_ptr      <= gnt_idx;
                pend_tag    <= gnt_idx;
            end
        end
    end

    // responses are suppressed during reset even if the buffer still returns data
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            rsp_vld[i] = ~rst & buf_rd_dat_vld & pend_vld_d & (pend_tag_d == log2_NUM_REQ'(i));
    end

    assign rsp_dat = buf_rd_dat;
endmodule

// File: tb/tb_center_buf_rd_arb.sv
// tb_center_buf_rd_arb: directed checks plus a per-cycle reference model of the read arbiter
module tb_center_buf_rd_arb;
    localparam int DW = 256;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic [N-1:0]  req_vld;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_rdy;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_dat;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic          buf_rd_dat_vld = 1'b0;
    logic [DW-1:0] buf_rd_dat = '0;
    logic [N-1:0]  rsp_vld;
    logic [DW-1:0] rsp_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    center_buf_rd_arb dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_dat(buf_wr_dat),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_rd_dat_vld(buf_rd_dat_vld), .buf_rd_dat(buf_rd_dat),
        .rsp_vld(rsp_vld), .rsp_dat(rsp_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // centre buffer: one-cycle read latency, not reset by rst
    logic [DW-1:0] bmem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) bmem[i] = '0;
    always @(posedge clk) begin
        buf_rd_dat_vld <= buf_rd_en;
        buf_rd_dat     <= bmem[buf_rd_addr];
        if (buf_wr_en) bmem[buf_wr_addr] <= buf_wr_dat;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model: memory image, last winner and a queue of reads due at a given cycle
    typedef struct {
        int            due;
        int            tag;
        logic [DW-1:0] dat;
    } rd_t;
    rd_t           q[$];
    logic [DW-1:0] mm [DEPTH];
    int            last = N - 1;
    int            w;
    logic [N-1:0]  e_rdy;
    logic [N-1:0]  e_rsp;
    logic [DW-1:0] e_dat;
    initial for (int i = 0; i < DEPTH; i++) mm[i] = '0;

    always @(negedge clk) begin
        e_rdy = '0;
        e_rsp = '0;
        e_dat = '0;
        w = -1;
        if (rst) begin
            q.delete();
            last = N - 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last + k) % N;
                if (w < 0 && req_vld[i] && !(wr_vld && wr_addr == req_addr[i*AW +: AW])) w = i;
            end
            if (w >= 0) e_rdy[w] = 1'b1;
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            if (q.size() > 0 && q[0].due == cyc) begin
                e_rsp[q[0].tag] = 1'b1;
                e_dat = q[0].dat;
                void'(q.pop_front());
            end
        end
        chk("m_req_rdy", DW'(req_rdy), DW'(e_rdy));
        chk("m_rsp_vld", DW'(rsp_vld), DW'(e_rsp));
        if (e_rsp != '0) chk("m_rsp_dat", rsp_dat, e_dat);
        if (w >= 0) begin
            q.push_back('{due: cyc + 2, tag: w, dat: mm[req_addr[w*AW +: AW]]});
            last = w;
        end
        if (!rst && wr_vld) mm[wr_addr] = wr_dat;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    int cnt0;
    int cnt1;

    initial begin
        rst = 1'b1;
        wr_vld = 1'b0;
        wr_addr = '0;
        wr_dat = '0;
        req_vld = 4'hF;
        req_addr = '0;
        nxt();
        nxt();
        neg();
        chk("rst_req_rdy", DW'(req_rdy), '0);
        chk("rst_rsp_vld", DW'(rsp_vld), '0);
        chk("rst_buf_wr_en", DW'(buf_wr_en), '0);
        chk("rst_buf_rd_en", DW'(buf_rd_en), '0);
        chk("rst_buf_rd_addr", DW'(buf_rd_addr), '0);
        chk("rst_buf_wr_dat", buf_wr_dat, '0);
        nxt();
        rst = 1'b0;
        req_vld = '0;

        // write 5 then a lone read of 5 two cycles later
        wr_vld = 1'b1; wr_addr = 5; wr_dat = 'hA5;
        nxt();
        wr_vld = 1'b0;
        nxt();
        req_vld = 4'b0100; req_addr[2*AW +: AW] = 5;
        neg(); chk("t1_req_rdy", DW'(req_rdy), DW'(4'b0100));
        nxt();
        req_vld = '0;
        neg(); chk("t1_buf_rd_en", DW'(buf_rd_en), 1);
        chk("t1_buf_rd_addr", DW'(buf_rd_addr), 5);
        nxt();
        neg(); chk("t1_rsp_vld", DW'(rsp_vld), DW'(4'b0100));
        chk("t1_rsp_dat", rsp_dat, 'hA5);

        // preload 0..3 and 7, then reset and let everybody request
        for (int i = 0; i < 5; i++) begin
            nxt();
            wr_vld = 1'b1;
            wr_addr = (i < 4) ? AW'(i) : AW'(7);
            wr_dat = (i < 4) ? DW'('h10 + i) : DW'('h11);
        end
        nxt();
        wr_vld = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
        req_vld = 4'hF;
        for (int k = 0; k < 6; k++) begin
            neg();
            if (k < 4) chk("t2_req_rdy", DW'(req_rdy), DW'(1 << k));
            if (k >= 2) begin
                chk("t2_rsp_vld", DW'(rsp_vld), DW'(1 << (k - 2)));
                chk("t2_rsp_dat", rsp_dat, DW'('h10 + k - 2));
            end
            nxt();
        end

        // same-address write defers requester 1 by one cycle
        wr_vld = 1'b1; wr_addr = 7; wr_dat = 'h77;
        req_vld = 4'b0010; req_addr[1*AW +: AW] = 7;
        neg(); chk("t3_req_rdy_blocked", DW'(req_rdy), '0);
        nxt();
        wr_vld = 1'b0;
        neg(); chk("t3_req_rdy_granted", DW'(req_rdy), DW'(4'b0010));
        nxt();
        req_vld = '0;
        neg(); chk("t3_rsp_vld_early", DW'(rsp_vld), '0);
        nxt();
        neg(); chk("t3_rsp_vld", DW'(rsp_vld), DW'(4'b0010));
        chk("t3_rsp_dat", rsp_dat, 'h77);

        // requester 3 wins first to set rr_ptr=3, then requester 0 collides
        nxt();
        req_vld = 4'b1000; req_addr[3*AW +: AW] = 2;
        nxt();
        wr_vld = 1'b1; wr_addr = 9; wr_dat = 'h99;
        req_vld = 4'b1001; req_addr[0 +: AW] = 9;
        neg(); chk("t4_req_rdy_mask", DW'(req_rdy), DW'(4'b1000));
        nxt();
        wr_vld = 1'b0;
        neg(); chk("t4_req_rdy_next", DW'(req_rdy), DW'(4'b0001));
        nxt();
        req_vld = '0;
        nxt();

        // two continuous requesters share grants evenly
        req_addr[0 +: AW] = 0; req_addr[1*AW +: AW] = 1;
        req_vld = 4'b0011;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 100; k++) begin
            neg();
            cnt0 += int'(req_rdy[0]);
            cnt1 += int'(req_rdy[1]);
            nxt();
        end
        req_vld = '0;
        chk("t5_fair0_in_49_51", DW'(cnt0 >= 49 && cnt0 <= 51), 1);
        chk("t5_fair1_in_49_51", DW'(cnt1 >= 49 && cnt1 <= 51), 1);
        nxt();
        nxt();

        // reset one cycle after a grant
        req_vld = 4'b0100; req_addr[2*AW +: AW] = 3;
        neg(); chk("t6_req_rdy", DW'(req_rdy), DW'(4'b0100));
        nxt();
        req_vld = '0;
        rst = 1'b1;
        neg(); chk("t6_req_rdy_rst", DW'(req_rdy), '0);
        nxt();
        rst = 1'b0;
        neg(); chk("t6_rsp_vld_dropped", DW'(rsp_vld), '0);

        // reset while the buffer is already returning data
        nxt();
        req_vld = 4'b0100;
        nxt();
        req_vld = '0;
        nxt();
        rst = 1'b1;
        neg(); chk("t6b_rsp_vld_rst", DW'(rsp_vld), '0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
        req_vld = 4'hF;
        neg(); chk("t6b_first_grant", DW'(req_rdy), DW'(4'b0001));
        nxt();
        req_vld = '0;
        repeat (4) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
